// File: rtl/zz_rle_encoder_pkg.sv
// Shared definitions for the zigzag run-length coefficient encoder:
// default widths, symbol field widths and the FSM state encoding.
package zz_rle_encoder_pkg;

   localparam int IN_WIDTH_DEF = 8;
   localparam int CW_DEF       = IN_WIDTH_DEF + 4;

   localparam int RUN_W    = 6;
   localparam int DC_W     = 1;
   localparam int EOB_W    = 1;
   localparam int IDX_W    = 6;
   localparam int LAST_IDX = 63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SCAN,
      ST_EOB,
      ST_FIN
   } zz_state_t;

endpackage

// File: rtl/zz_rle_encoder_lut.sv
// Zigzag index to (row,col) map for an 8x8 block, purely combinational.
module zz_lut
   import zz_rle_encoder_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [2:0]       row,
   output logic [2:0]       col
);

   int n;
   int r;
   int c;

   // Walk the 15 anti-diagonals, alternating direction, and count only
   // positions that fall inside the 8x8 block.
   always_comb begin
      row = '0;
      col = '0;
      n   = 0;
      r   = 0;
      c   = 0;
      for (int d = 0; d < 15; d++) begin
         for (int k = 0; k <= d; k++) begin
            r = ((d % 2) == 0) ? (d - k) : k;
            c = d - r;
            if (r < 8 && c < 8) begin
               if (idx == IDX_W'(n)) begin
                  row = 3'(r);
                  col = 3'(c);
               end
               n = n + 1;
            end
         end
      end
   end

endmodule

// File: rtl/zz_rle_encoder.sv
// Reads an 8x8 coefficient block in zigzag order and emits DC-difference,
// run/level AC and end-of-block symbols through a single-entry output slot.
module zz_rle_encoder
   import zz_rle_encoder_pkg::*;
#(
   parameter  int IN_WIDTH = IN_WIDTH_DEF,
   localparam int CW       = IN_WIDTH + 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [2:0]             rd_row,
   output logic [2:0]             rd_col,
   input  logic signed [CW-1:0]   coef_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RUN_W-1:0]       out_run,
   output logic signed [CW:0]     out_level,
   output logic [DC_W-1:0]        out_dc,
   output logic [EOB_W-1:0]       out_eob,
   output logic                   busy,
   output logic                   done
);

   zz_state_t          state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [RUN_W-1:0]   run;
   logic signed [CW-1:0] prev_dc;
   logic               tail;
   logic               advance;
   logic               last;

   assign advance = !out_valid || out_ready;
   assign last    = (idx == IDX_W'(LAST_IDX));
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_FIN);

   // While the slot is blocked, re-present the pending index so the
   // one-cycle-latency buffer keeps returning the same coefficient.
   always_comb begin
      rd_idx = '0;
      if (state == ST_SCAN) begin
         rd_idx = (advance && !tail) ? idx + 1'b1 : idx;
      end
   end

   zz_lut u_lut (
      .idx (rd_idx),
      .row (rd_row),
      .col (rd_col)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         run       <= '0;
         prev_dc   <= '0;
         tail      <= 1'b0;
         out_valid <= 1'b0;
         out_run   <= '0;
         out_level <= '0;
         out_dc    <= '0;
         out_eob   <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state <= ST_SCAN;
               idx   <= '0;
               run   <= '0;
               tail  <= 1'b0;
            end
            ST_SCAN: begin
               // tail: idx63 was nonzero and its symbol still waits in the slot
               if (tail) begin
                  if (out_ready) begin
                     state <= ST_FIN;
                  end
               end else if (advance) begin
                  idx <= idx + 1'b1;
                  if (idx == '0) begin
                     out_valid <= 1'b1;
                     out_run   <= '0;
                     out_level <= {coef_in[CW-1], coef_in} - {prev_dc[CW-1], prev_dc};
                     out_dc    <= 1'b1;
                     out_eob   <= 1'b0;
                     prev_dc   <= coef_in;
                  end else if (coef_in != '0) begin
                     out_valid <= 1'b1;
                     out_run   <= run;
                     out_level <= {coef_in[CW-1], coef_in};
                     out_dc    <= 1'b0;
                     out_eob   <= 1'b0;
                     run       <= '0;
                     tail      <= last;
                  end else if (last) begin
                     out_valid <= 1'b1;
                     out_run   <= '0;
                     out_level <= '0;
                     out_dc    <= 1'b0;
                     out_eob   <= 1'b1;
                     run       <= '0;
                     state     <= ST_EOB;
                  end else begin
                     run <= run + 1'b1;
                  end
               end
            end
            ST_EOB: begin
               if (out_ready) begin
                  state <= ST_FIN;
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zz_rle_encoder.sv
// Randomized bench for zz_rle_encoder: a table-driven zigzag model builds the
// expected symbol list per block and a negedge monitor scores the stream.
module tb_zz_rle_encoder;

   localparam int CW = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [2:0]           rd_row;
   logic [2:0]           rd_col;
   logic signed [CW-1:0] coef_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [5:0]           out_run;
   logic signed [CW:0]   out_level;
   logic [0:0]           out_dc;
   logic [0:0]           out_eob;
   logic                 busy;
   logic                 done;

   typedef struct {
      int run;
      int level;
      int dc;
      int eob;
   } sym_t;

   sym_t exp_q[$];
   sym_t e;
   int   blk[64];
   int   model_prev_dc;
   int   checks;
   int   failures;

   int zz_tab[64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,
                      12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,
                      35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
                      58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

   bit prev_stall;
   bit prev_done;
   int p_run, p_level, p_dc, p_eob, p_row, p_col;

   zz_rle_encoder #(.IN_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .coef_in   (coef_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_run   (out_run),
      .out_level (out_level),
      .out_dc    (out_dc),
      .out_eob   (out_eob),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Transpose buffer stand-in with one cycle of read latency.
   always @(posedge clk) begin
      coef_in <= CW'(blk[int'(rd_row) * 8 + int'(rd_col)]);
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void buildExpected();
      sym_t s;
      int   v;
      int   r;
      v = blk[zz_tab[0]];
      s.run = 0; s.level = v - model_prev_dc; s.dc = 1; s.eob = 0;
      exp_q.push_back(s);
      model_prev_dc = v;
      r = 0;
      for (int i = 1; i < 64; i++) begin
         v = blk[zz_tab[i]];
         if (v == 0) begin
            r++;
         end else begin
            s.run = r; s.level = v; s.dc = 0; s.eob = 0;
            exp_q.push_back(s);
            r = 0;
         end
      end
      if (blk[zz_tab[63]] == 0) begin
         s.run = 0; s.level = 0; s.dc = 0; s.eob = 1;
         exp_q.push_back(s);
      end
   endfunction

   function automatic logic readyFor(input int mode, input int cyc);
      if (mode == 1) return ($urandom_range(0, 3) != 0);
      if (mode == 2) return !(cyc >= 3 && cyc < 8);
      return 1'b1;
   endfunction

   function automatic void clearBlk();
      for (int i = 0; i < 64; i++) blk[i] = 0;
   endfunction

   function automatic void randomBlk();
      for (int i = 0; i < 64; i++) begin
         blk[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) - 2048 : 0;
      end
   endfunction

   // Scoreboard and stall-stability monitor, sampling between active edges.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("stall_valid", int'(out_valid), 1);
            checkOutput("stall_run", int'(out_run), p_run);
            checkOutput("stall_level", int'(out_level), p_level);
            checkOutput("stall_dc", int'(out_dc), p_dc);
            checkOutput("stall_eob", int'(out_eob), p_eob);
            if (out_valid && !out_ready) begin
               checkOutput("stall_rd_row", int'(rd_row), p_row);
               checkOutput("stall_rd_col", int'(rd_col), p_col);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("extra_symbol", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("sym_run", int'(out_run), e.run);
               checkOutput("sym_level", int'(out_level), e.level);
               checkOutput("sym_dc", int'(out_dc), e.dc);
               checkOutput("sym_eob", int'(out_eob), e.eob);
            end
         end
         if (done) begin
            checkOutput("done_pulse_width", int'(prev_done), 0);
         end
         prev_done  = done;
         prev_stall = out_valid && !out_ready;
         p_run   = int'(out_run);
         p_level = int'(out_level);
         p_dc    = int'(out_dc);
         p_eob   = int'(out_eob);
         p_row   = int'(rd_row);
         p_col   = int'(rd_col);
      end
   end

   task automatic resetDut();
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_rd_row", int'(rd_row), 0);
      checkOutput("rst_rd_col", int'(rd_col), 0);
      checkOutput("rst_out_run", int'(out_run), 0);
      checkOutput("rst_out_level", int'(out_level), 0);
      checkOutput("rst_out_dc", int'(out_dc), 0);
      checkOutput("rst_out_eob", int'(out_eob), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_prev_dc = 0;
      exp_q.delete();
   endtask

   // mode 0: always ready, 1: random backpressure, 2: five-cycle stall window.
   task automatic applyStimulus(input int mode, input bit poke_start);
      int cyc;
      bit got_done;
      buildExpected();
      @(posedge clk);
      #1;
      start = 1'b1;
      out_ready = readyFor(mode, 0);
      cyc = 0;
      got_done = 1'b0;
      while (!got_done && cyc < 400) begin
         @(posedge clk);
         cyc++;
         #1;
         start = poke_start && (cyc == 20);
         out_ready = readyFor(mode, cyc);
         @(negedge clk);
         if (done) got_done = 1'b1;
      end
      checkOutput("done_seen", int'(got_done), 1);
      if (mode == 0) begin
         checkOutput("latency_within_66", int'((cyc - 1) <= 66), 1);
      end
      checkOutput("symbols_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic midReset();
      randomBlk();
      buildExpected();
      @(posedge clk);
      #1;
      start = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      model_prev_dc = 0;
      @(negedge clk);
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      repeat (5) @(posedge clk);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      model_prev_dc = 0;
      clearBlk();
      $display("[TB] zz_rle_encoder bench starting");

      resetDut();

      clearBlk();
      applyStimulus(0, 1'b0);

      clearBlk(); blk[0] = 40;
      applyStimulus(0, 1'b0);
      clearBlk(); blk[0] = 100; blk[2] = -3;
      applyStimulus(0, 1'b0);

      resetDut();
      clearBlk(); blk[0] = 5; blk[63] = 7;
      applyStimulus(0, 1'b0);

      clearBlk(); blk[0] = 40;
      applyStimulus(0, 1'b0);
      clearBlk(); blk[0] = 40;
      applyStimulus(0, 1'b0);
      clearBlk(); blk[0] = 100; blk[2] = -3;
      applyStimulus(2, 1'b0);

      midReset();
      clearBlk(); blk[0] = -2048;
      applyStimulus(0, 1'b0);

      clearBlk(); blk[0] = 2047; blk[1] = 2047; blk[63] = -2048;
      applyStimulus(1, 1'b1);

      for (int i = 0; i < 8; i++) begin
         randomBlk();
         applyStimulus(i % 2, i == 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/zz_rle_encoder.md
ZZ_RLE_ENCODER -- requirements
Module: zz_rle_encoder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, giving the pixel width; the coefficient width CW = IN_WIDTH+4.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have start, input, 1 bit: one-cycle pulse meaning an 8x8 coefficient block is ready in the upstream transpose buffer.
REQ-005 SHALL have rd_row and rd_col, outputs, 3 bits each: the buffer read address in zigzag order.
REQ-006 SHALL have coef_in, input, CW bits, signed: buffer data for the address presented in the previous cycle (1-cycle read latency).
REQ-007 SHALL have out_valid (output, 1), out_ready (input, 1), out_run (output, 6), out_level (output, CW+1, signed), out_dc (output, 1) and out_eob (output, 1): the symbol stream.
REQ-008 SHALL have busy (output, 1) and done (output, 1): block in progress, and a one-cycle completion pulse.

Function
REQ-009 SHALL use the JPEG zigzag order, given here as (row,col): idx0 (0,0), idx1 (0,1), idx2 (1,0), idx3 (2,0), idx4 (1,1), idx5 (0,2), ..., idx63 (7,7).
REQ-010 SHALL have the FSM states IDLE, FETCH, SCAN, EOB and FIN.
- IDLE->FETCH on start.
- FETCH presents idx0, then goes to SCAN.
- SCAN->EOB when idx63 is evaluated as zero; SCAN->FIN when idx63 is nonzero and its symbol is accepted.
- EOB->FIN on the EOB handshake.
- FIN->IDLE after one cycle, with done=1 in that cycle.
REQ-011 SHALL ignore start while busy; busy=1 in every state except IDLE.
REQ-012 SHALL emit idx0 as a DC symbol: out_dc=1, out_run=0, out_level = coef_in - prev_dc, computed exactly in CW+1 bits; prev_dc SHALL then update to coef_in.
REQ-013 SHALL increment an internal zero run counter (6 bits) for each zero AC coefficient (idx1..63), emitting nothing for it.
REQ-014 SHALL emit a symbol for each nonzero AC coefficient: out_run = current run, out_level = coef_in sign-extended to CW+1, out_dc=0, out_eob=0; the run SHALL then clear to 0.
REQ-015 SHALL emit the EOB symbol when trailing zeros reach idx63: run=0, level=0, out_eob=1; no EOB SHALL be emitted when idx63 is nonzero.
REQ-016 SHALL hold the symbol outputs in a registered output slot; out_valid stays high and all symbol fields stay stable until out_ready=1.
REQ-017 SHALL freeze the zigzag index, the run counter and rd_row/rd_col while the slot is full and out_ready=0, so that coef_in repeats the pending coefficient; no coefficient may be lost or duplicated.
REQ-018 SHALL sustain one coefficient per cycle when out_ready is held high; a block of 64 coefficients SHALL take at most 66 cycles from start to done, excluding stall cycles.
REQ-019 SHALL allow a symbol handshake and loading of the next symbol into the slot in the same cycle.
REQ-020 SHALL allow start to be accepted in the cycle after done.

Reset
REQ-021 SHALL, on rst=1, set: state IDLE; out_valid=0; busy=0; done=0; rd_row=0; rd_col=0; out_run=0; out_level=0; out_dc=0; out_eob=0; run counter=0; prev_dc=0.
REQ-022 SHALL, when rst is asserted mid-block, abandon the block with no further symbols; the next start begins a fresh block with prev_dc=0.

Structure
REQ-023 SHALL place IN_WIDTH/CW defaults, the state encoding and the EOB/DC symbol field widths in the shared codec package.
REQ-024 SHALL implement the zigzag index-to-(row,col) map as the sub-module zz_lut: a combinational 6-bit index in, 3-bit row and 3-bit col out.

Verification
REQ-025 SHALL cover: rst held 2 cycles -> every output at its REQ-021 value, and the bench sees rd addr (0,0).
REQ-026 SHALL cover: all-zero block with prev_dc=0 -> DC (run0, level0), then EOB, then done pulse; 2 symbols total.
REQ-027 SHALL cover: prev_dc=40, next block with DC=100 and (0,2)=-3, rest zero -> DC level 60; then AC run4 level -3; then EOB.
REQ-028 SHALL cover: DC=5, (7,7)=7, rest zero, prev_dc=0 -> DC level 5; then run62 level 7; no EOB; done.
REQ-029 SHALL cover: out_ready=0 for 5 cycles during the REQ-027 block -> symbol fields and rd addr stable; the symbol sequence is identical to the unstalled case.
REQ-030 SHALL cover: rst pulse after 10 coefficients of a block, then DC=-2048 with rest zero -> DC level -2048 (prev_dc cleared), then EOB.
